// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider for DIV/DIVU
// Latches operands at start, produces quotient/remainder 32 cycles later with a one-cycle ready strobe.
module div_iter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              signed_div,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              cancel,
   output logic              ready,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  rem_r;
   logic [DATA_W-1:0]  shift_r;
   logic [DATA_W-1:0]  dvsr_r;
   logic               q_neg;
   logic               r_neg;

   logic               dvd_neg;
   logic               dvs_neg;
   logic [DATA_W-1:0]  dvd_abs;
   logic [DATA_W-1:0]  dvs_abs;
   logic [DATA_W:0]    rem_sh;
   logic [DATA_W-1:0]  diff;
   logic               q_bit;
   logic [DATA_W-1:0]  rem_next;
   logic [DATA_W-1:0]  shift_next;
   logic               last_iter;

   assign dvd_neg = signed_div & dividend[DATA_W-1];
   assign dvs_neg = signed_div & divisor[DATA_W-1];
   assign dvd_abs = dvd_neg ? -dividend : dividend;
   assign dvs_abs = dvs_neg ? -divisor : divisor;

   // Partial remainder is always below the divisor, so the low DATA_W bits of
   // the difference are exact whenever the trial subtraction succeeds.
   assign rem_sh     = {rem_r, shift_r[DATA_W-1]};
   assign q_bit      = (rem_sh >= {1'b0, dvsr_r});
   assign diff       = rem_sh[DATA_W-1:0] - dvsr_r;
   assign rem_next   = q_bit ? diff : rem_sh[DATA_W-1:0];
   assign shift_next = {shift_r[DATA_W-2:0], q_bit};
   assign last_iter  = (cnt == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         rem_r     <= '0;
         shift_r   <= '0;
         dvsr_r    <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         ready     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (cancel) begin
         state <= IDLE;
         ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready <= 1'b0;
               if (start) begin
                  q_neg   <= dvd_neg ^ dvs_neg;
                  r_neg   <= dvd_neg;
                  dvsr_r  <= dvs_abs;
                  cnt     <= '0;
                  rem_r   <= '0;
                  shift_r <= dvd_abs;
                  if (divisor == '0) begin
                     state     <= DONE;
                     ready     <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               rem_r   <= rem_next;
               shift_r <= shift_next;
               cnt     <= cnt + CNT_W'(1);
               if (last_iter) begin
                  state     <= DONE;
                  ready     <= 1'b1;
                  quotient  <= q_neg ? -shift_next : shift_next;
                  remainder <= r_neg ? -rem_next : rem_next;
               end
            end
            DONE: begin
               state <= IDLE;
               ready <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - randomized self-checking bench for div_iter
// Expected results come from 64-bit arithmetic division of the raw operands.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        signed_div = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        cancel = 1'b0;
   logic        ready;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_ready_cyc = 0;

   div_iter #(.DATA_W(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .signed_div (signed_div),
      .dividend   (dividend),
      .divisor    (divisor),
      .cancel     (cancel),
      .ready      (ready),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Called on a negedge; raises start and waits (bounded) until ready is seen.
   task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output int lat);
      signed_div = sg;
      dividend   = a;
      divisor    = b;
      start      = 1'b1;
      lat        = 0;
      do begin
         @(negedge clk);
         lat++;
         if (scramble && !ready) begin
            dividend   = $urandom;
            divisor    = $urandom;
            signed_div = 1'($urandom_range(1));
         end
      end while (!ready && lat < 100);
      last_ready_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic check_op(input string tag, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input bit scramble);
      int          lat;
      logic [31:0] eq, er;
      model(sg, a, b, eq, er);
      run_div(sg, a, b, scramble, lat);
      chk({tag, "_lat"}, 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
      chk({tag, "_q"}, quotient, eq);
      chk({tag, "_r"}, remainder, er);
      @(negedge clk);
      chk({tag, "_gap"}, 32'(ready), 32'd0);
   endtask

   initial begin
      int          first_ready;
      int          highs;
      logic [31:0] ra, rb;
      logic        rs;

      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_q", quotient, 32'd0);
      chk("rst_r", remainder, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      check_op("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
      check_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
      check_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
      check_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
      check_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check_op("u5_0", 1'b0, 32'd5, 32'd0, 1'b0);
      check_op("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);

      // Back-to-back: second start in the IDLE cycle right after ready.
      check_op("b2b_a", 1'b0, 32'd100, 32'd7, 1'b0);
      first_ready = last_ready_cyc;
      check_op("b2b_b", 1'b0, 32'd50, 32'd3, 1'b0);
      chk("b2b_spacing", 32'(last_ready_cyc - first_ready), 32'd34);

      // Cancel in BUSY cycle 10: previous result (16,2) must survive.
      signed_div = 1'b0;
      dividend   = 32'd1000;
      divisor    = 32'd3;
      start      = 1'b1;
      repeat (10) @(negedge clk);
      cancel = 1'b1;
      start  = 1'b0;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_ready", 32'(ready), 32'd0);
      chk("cancel_q", quotient, 32'd16);
      chk("cancel_r", remainder, 32'd2);
      highs = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) highs++;
      end
      chk("cancel_no_ready", 32'(highs), 32'd0);
      check_op("post_cancel", 1'b0, 32'd100, 32'd7, 1'b0);

      // cancel together with start in IDLE must not start anything.
      dividend = 32'd9;
      divisor  = 32'd0;
      start    = 1'b1;
      cancel   = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cancel = 1'b0;
      highs  = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) highs++;
      end
      chk("cancel_idle_no_ready", 32'(highs), 32'd0);
      chk("cancel_idle_q", quotient, 32'd14);

      // Asynchronous reset mid-BUSY, applied between clock edges.
      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      repeat (5) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_ready", 32'(ready), 32'd0);
      chk("arst_q", quotient, 32'd0);
      chk("arst_r", remainder, 32'd0);
      start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check_op("post_rst", 1'b0, 32'd100, 32'd7, 1'b0);

      for (int i = 0; i < 24; i++) begin
         rs = 1'($urandom_range(1));
         ra = $urandom;
         case ($urandom_range(3))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: rb = $urandom;
         endcase
         check_op($sformatf("rnd%0d", i), rs, ra, rb, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout obs=%0d exp=done", cyc);
      $fatal(1, "timeout");
   end

endmodule
